// File: rtl/fc_layer_sequencer_if.sv
// ---------------------------------------------------------------------------
// fc_layer_sequencer_if
//
// Bus between the layer sequencer and the shared fully-connected engine.
//   master : the sequencer side (launches layers, serves input reads,
//            receives result writes)
//   slave  : the engine side
//
// Signals
//   eng_enable        seq->eng  one-cycle launch pulse
//   eng_layer         seq->eng  active layer index (weight-bank select)
//   eng_in_size       seq->eng  input vector length of the active layer
//   eng_out_size      seq->eng  output vector length of the active layer
//   eng_input_addr    eng->seq  requested input index
//   eng_input_data    seq->eng  registered activation read
//   eng_input_valid   seq->eng  eng_input_data belongs to eng_input_addr
//   eng_output_data   eng->seq  result value
//   eng_output_addr   eng->seq  result index
//   eng_output_valid  eng->seq  result capture strobe
//   eng_done          eng->seq  layer complete
// ---------------------------------------------------------------------------
interface fc_layer_sequencer_if #(
  parameter int AW     = 9,
  parameter int DATA_W = 16
);
  logic              eng_enable;
  logic [1:0]        eng_layer;
  logic [AW:0]       eng_in_size;
  logic [AW:0]       eng_out_size;
  logic [AW-1:0]     eng_input_addr;
  logic [DATA_W-1:0] eng_input_data;
  logic              eng_input_valid;
  logic [DATA_W-1:0] eng_output_data;
  logic [AW-1:0]     eng_output_addr;
  logic              eng_output_valid;
  logic              eng_done;

  modport master (
    output eng_enable, eng_layer, eng_in_size, eng_out_size,
           eng_input_data, eng_input_valid,
    input  eng_input_addr, eng_output_data, eng_output_addr,
           eng_output_valid, eng_done
  );

  modport slave (
    input  eng_enable, eng_layer, eng_in_size, eng_out_size,
           eng_input_data, eng_input_valid,
    output eng_input_addr, eng_output_data, eng_output_addr,
           eng_output_valid, eng_done
  );
endinterface

// File: rtl/fc_layer_sequencer.sv
// ---------------------------------------------------------------------------
// fc_layer_sequencer
//
// Drives one shared fully-connected engine through a three-layer chain
// SIZE0 -> SIZE1 -> SIZE2 -> SIZE3 using two ping-pong activation buffers.
// Layers 0 and 2 read buffer A and write buffer B; layer 1 reads B and
// writes A, so the final result always lands in B[0..SIZE3-1].
//
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   start                    begin an inference (accepted in IDLE only)
//   busy / done              inference in progress / one-cycle completion
//   err / err_code           sticky error, 1 = timeout, 2 = output index
//                            out of range; cleared by an accepted start
//   act_wr_en/addr/data      host load port for buffer A (idle only)
//   res_rd_addr/res_rd_data  combinational result read of buffer B
//   eng                      engine bus (master side)
// ---------------------------------------------------------------------------
module fc_layer_sequencer #(
  parameter int SIZE0       = 400,
  parameter int SIZE1       = 120,
  parameter int SIZE2       = 84,
  parameter int SIZE3       = 10,
  parameter int DATA_W      = 16,
  parameter int RELU_HIDDEN = 1,
  parameter int TIMEOUT     = 65535,
  localparam int AW         = $clog2(SIZE0)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  input  logic                  act_wr_en,
  input  logic [AW-1:0]         act_wr_addr,
  input  logic [DATA_W-1:0]     act_wr_data,
  input  logic [AW-1:0]         res_rd_addr,
  output logic [DATA_W-1:0]     res_rd_data,
  fc_layer_sequencer_if.master  eng
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   DEPTH    = (AW+1)'(SIZE0);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_SWAP,
    S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        layer_q, layer_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [CW-1:0]     tmo_q, tmo_d;
  logic [AW-1:0]     rd_addr_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              run_seen_q;

  logic [DATA_W-1:0] buf_a_q [SIZE0];
  logic [DATA_W-1:0] buf_b_q [SIZE0];

  logic [AW:0]       in_size;
  logic [AW:0]       out_size;
  logic              src_is_b;
  logic [DATA_W-1:0] src_word;
  logic [DATA_W-1:0] cap_data;
  logic              out_ok;
  logic              cap_en;
  logic              load_en;
  logic              a_we;
  logic [AW-1:0]     a_waddr;
  logic [DATA_W-1:0] a_wdata;
  logic              b_we;

  // Layer geometry follows the latched layer index, so it is stable from
  // LAUNCH through SWAP and sits at layer 0 after reset.
  always_comb begin
    in_size  = (AW+1)'(SIZE0);
    out_size = (AW+1)'(SIZE1);
    unique case (layer_q)
      2'd1: begin
        in_size  = (AW+1)'(SIZE1);
        out_size = (AW+1)'(SIZE2);
      end
      2'd2: begin
        in_size  = (AW+1)'(SIZE2);
        out_size = (AW+1)'(SIZE3);
      end
      default: begin
        in_size  = (AW+1)'(SIZE0);
        out_size = (AW+1)'(SIZE1);
      end
    endcase
  end

  assign src_is_b = (layer_q == 2'd1);

  // Indices beyond the buffer depth read as zero instead of touching
  // unimplemented storage.
  always_comb begin
    src_word = '0;
    if ({1'b0, eng.eng_input_addr} < DEPTH) begin
      src_word = src_is_b ? buf_b_q[eng.eng_input_addr]
                          : buf_a_q[eng.eng_input_addr];
    end
  end

  always_comb begin
    res_rd_data = '0;
    if ({1'b0, res_rd_addr} < DEPTH) begin
      res_rd_data = buf_b_q[res_rd_addr];
    end
  end

  // Hidden-layer outputs are clamped at zero; the final layer keeps its sign.
  always_comb begin
    cap_data = eng.eng_output_data;
    if ((RELU_HIDDEN != 0) && (layer_q != 2'd2) && eng.eng_output_data[DATA_W-1]) begin
      cap_data = '0;
    end
  end

  assign out_ok  = ({1'b0, eng.eng_output_addr} < out_size);
  assign cap_en  = (state_q == S_RUN) && eng.eng_output_valid && out_ok;
  assign load_en = (state_q == S_IDLE) && act_wr_en && ({1'b0, act_wr_addr} < DEPTH);

  // Host loads and layer-1 captures never coincide (IDLE vs RUN), so
  // buffer A needs only one write port.
  assign a_we    = load_en || (cap_en && src_is_b);
  assign a_waddr = load_en ? act_wr_addr : eng.eng_output_addr;
  assign a_wdata = load_en ? act_wr_data : cap_data;
  assign b_we    = cap_en && !src_is_b;

  always_ff @(posedge clk) begin
    if (a_we) begin
      buf_a_q[a_waddr] <= a_wdata;
    end
    if (b_we) begin
      buf_b_q[eng.eng_output_addr] <= cap_data;
    end
  end

  // Next-state and control outputs.
  always_comb begin
    state_d    = state_q;
    layer_d    = layer_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    tmo_d      = tmo_q;
    busy       = 1'b0;
    done       = 1'b0;
    eng.eng_enable = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          layer_d    = 2'd0;
          err_d      = 1'b0;
          err_code_d = 2'd0;
          state_d    = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        busy           = 1'b1;
        eng.eng_enable = 1'b1;
        tmo_d          = '0;
        state_d        = S_RUN;
      end
      S_RUN: begin
        busy  = 1'b1;
        tmo_d = tmo_q + 1'b1;
        if (eng.eng_output_valid && !out_ok) begin
          err_d      = 1'b1;
          err_code_d = 2'd2;
        end
        // A layer that finishes on its last allowed cycle still counts.
        if (eng.eng_done) begin
          state_d = S_SWAP;
        end else if (tmo_q == TMO_LAST) begin
          err_d      = 1'b1;
          err_code_d = 2'd1;
          state_d    = S_FINISH;
        end
      end
      S_SWAP: begin
        busy = 1'b1;
        if (layer_q == 2'd2) begin
          state_d = S_FINISH;
        end else begin
          layer_d = layer_q + 2'd1;
          state_d = S_LAUNCH;
        end
      end
      S_FINISH: begin
        // Code 1 is only ever set by the abort path, so it alone
        // distinguishes an aborted run from a completed one here.
        done    = (err_code_q != 2'd1);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      layer_q    <= 2'd0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      tmo_q      <= tmo_d;
    end
  end

  // Registered engine read port. run_seen_q keeps valid low on the first
  // RUN cycle, when the registered word still belongs to a previous layer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      run_seen_q <= 1'b0;
    end else if (state_q == S_RUN) begin
      rd_addr_q  <= eng.eng_input_addr;
      rd_data_q  <= src_word;
      run_seen_q <= 1'b1;
    end else begin
      run_seen_q <= 1'b0;
    end
  end

  assign eng.eng_layer       = layer_q;
  assign eng.eng_in_size     = in_size;
  assign eng.eng_out_size    = out_size;
  assign eng.eng_input_data  = rd_data_q;
  assign eng.eng_input_valid = (state_q == S_RUN) && run_seen_q &&
                               (rd_addr_q == eng.eng_input_addr);

  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
module tb_fc_layer_sequencer;
  localparam int SIZE0 = 400;
  localparam int SIZE1 = 120;
  localparam int SIZE2 = 84;
  localparam int SIZE3 = 10;
  localparam int DW    = 16;
  localparam int AW    = $clog2(SIZE0);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          start, busy, done, err;
  logic [1:0]    err_code;
  logic          act_wr_en;
  logic [AW-1:0] act_wr_addr, res_rd_addr;
  logic [DW-1:0] act_wr_data, res_rd_data;

  logic          start_to, busy_to, done_to, err_to;
  logic [1:0]    err_code_to;
  logic [DW-1:0] res_rd_data_to;

  fc_layer_sequencer_if #(.AW(AW), .DATA_W(DW)) ifc ();
  fc_layer_sequencer_if #(.AW(AW), .DATA_W(DW)) ifc_to ();

  fc_layer_sequencer #(
    .SIZE0(SIZE0), .SIZE1(SIZE1), .SIZE2(SIZE2), .SIZE3(SIZE3),
    .DATA_W(DW), .RELU_HIDDEN(1), .TIMEOUT(65535)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .err(err), .err_code(err_code), .act_wr_en(act_wr_en),
    .act_wr_addr(act_wr_addr), .act_wr_data(act_wr_data),
    .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data), .eng(ifc.master)
  );

  // Second instance with a short timeout and an engine that never finishes.
  fc_layer_sequencer #(
    .SIZE0(SIZE0), .SIZE1(SIZE1), .SIZE2(SIZE2), .SIZE3(SIZE3),
    .DATA_W(DW), .RELU_HIDDEN(1), .TIMEOUT(100)
  ) dut_to (
    .clk(clk), .reset_n(reset_n), .start(start_to), .busy(busy_to), .done(done_to),
    .err(err_to), .err_code(err_code_to), .act_wr_en(1'b0),
    .act_wr_addr('0), .act_wr_data('0),
    .res_rd_addr('0), .res_rd_data(res_rd_data_to), .eng(ifc_to.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic signed [DW-1:0] mA  [SIZE0];
  logic signed [DW-1:0] mL0 [SIZE1];
  logic signed [DW-1:0] mL1 [SIZE2];
  logic signed [DW-1:0] mL2 [SIZE3];
  int neg_l0, neg_l2;
  bit bad_l1;
  bit kill;

  // Engine stub behaviour: output j = (sum of all inputs + j) wrapped to DW bits.
  function automatic logic signed [DW-1:0] out_val(input int s, input int j);
    return DW'(s + j);
  endfunction

  function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] x);
    return (x < 0) ? '0 : x;
  endfunction

  task automatic build_model();
    int s;
    s = 0;
    for (int i = 0; i < SIZE0; i++) s += int'(mA[i]);
    for (int j = 0; j < SIZE1; j++) mL0[j] = relu((j == neg_l0) ? -16'sd5 : out_val(s, j));
    s = 0;
    for (int i = 0; i < SIZE1; i++) s += int'(mL0[i]);
    for (int j = 0; j < SIZE2; j++) mL1[j] = relu(out_val(s, j));
    s = 0;
    for (int i = 0; i < SIZE2; i++) s += int'(mL1[i]);
    for (int j = 0; j < SIZE3; j++) mL2[j] = (j == neg_l2) ? -16'sd5 : out_val(s, j);
  endtask

  function automatic int exp_src(input int lay, input int i);
    if (lay == 0 && i < SIZE0) return int'(mA[i]);
    if (lay == 1 && i < SIZE1) return int'(mL0[i]);
    if (lay == 2 && i < SIZE2) return int'(mL1[i]);
    return 0;
  endfunction

  // ---------------- scoreboard queues ----------------
  typedef struct packed {
    logic [SIZE3*DW-1:0] r;
    logic                e;
    logic [1:0]          code;
  } res_t;

  int   launch_q [$];
  res_t res_q    [$];
  int   results_seen = 0;

  function automatic int cfg_code(input int lay, input int n_in, input int n_out);
    return lay * 1000000 + n_in * 1000 + n_out;
  endfunction

  // ---------------- engine stub ----------------
  bit relaunch;

  task automatic eng_idle();
    ifc.eng_input_addr   = '0;
    ifc.eng_output_data  = '0;
    ifc.eng_output_addr  = '0;
    ifc.eng_output_valid = 1'b0;
    ifc.eng_done         = 1'b0;
  endtask

  task automatic run_layer();
    int lay, n_in, n_out, s, k;
    logic signed [DW-1:0] d;
    relaunch = 1'b0;
    lay   = int'(ifc.eng_layer);
    n_in  = int'(ifc.eng_in_size);
    n_out = int'(ifc.eng_out_size);
    s = 0;
    for (int i = 0; i < n_in; i++) begin
      @(posedge clk); #1;
      if (kill) begin eng_idle(); return; end
      ifc.eng_input_addr = AW'(i);
      for (k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (ifc.eng_input_valid || kill) break;
      end
      if (kill) begin eng_idle(); return; end
      chk("in_latency", k, 2);
      d = ifc.eng_input_data;
      chk("in_data", int'(d), exp_src(lay, i));
      s += int'(d);
    end
    if (lay == 1 && bad_l1) begin
      @(posedge clk); #1;
      ifc.eng_output_valid = 1'b1;
      ifc.eng_output_addr  = AW'(SIZE2);
      ifc.eng_output_data  = 16'h1234;
    end
    for (int j = 0; j < n_out; j++) begin
      @(posedge clk); #1;
      if (kill) begin eng_idle(); return; end
      ifc.eng_output_valid = 1'b1;
      ifc.eng_output_addr  = AW'(j);
      if ((lay == 0 && j == neg_l0) || (lay == 2 && j == neg_l2))
        ifc.eng_output_data = -16'sd5;
      else
        ifc.eng_output_data = out_val(s, j);
      ifc.eng_done = (j == n_out - 1);
    end
    @(posedge clk); #1;
    eng_idle();
    for (k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (ifc.eng_enable || done || kill) break;
    end
    if (kill) return;
    chk("done_to_next", k, 2);
    relaunch = ifc.eng_enable;
  endtask

  initial begin
    eng_idle();
    relaunch = 1'b0;
    forever begin
      @(negedge clk);
      if (ifc.eng_enable && !kill) begin
        relaunch = 1'b1;
        while (relaunch && !kill) run_layer();
      end
    end
  end

  // ---------------- monitors ----------------
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (ifc.eng_enable) begin
        if (launch_q.size() == 0) begin
          chk("unexpected_launch", int'(ifc.eng_layer) + 100, 0);
        end else begin
          e = launch_q.pop_front();
          chk("launch_cfg", cfg_code(int'(ifc.eng_layer), int'(ifc.eng_in_size),
                                     int'(ifc.eng_out_size)), e);
          chk("launch_busy", int'(busy), 1);
        end
      end
    end
  end

  initial begin
    res_t x;
    logic signed [DW-1:0] ev;
    res_rd_addr = '0;
    forever begin
      @(negedge clk);
      if (done) begin
        if (res_q.size() == 0) begin
          chk("unexpected_done", int'(done) + 100, 0);
        end else begin
          x = res_q.pop_front();
          chk("done_busy", int'(busy), 0);
          chk("done_err", int'(err), int'(x.e));
          chk("done_code", int'(err_code), int'(x.code));
          @(negedge clk);
          chk("done_width", int'(done), 0);
          for (int k = 0; k < SIZE3; k++) begin
            res_rd_addr = AW'(k);
            #1;
            ev = x.r[k*DW +: DW];
            chk($sformatf("result[%0d]", k), int'($signed(res_rd_data)), int'(ev));
            @(negedge clk);
          end
        end
        results_seen++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_state();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_code", int'(err_code), 0);
    chk("rst_enable", int'(ifc.eng_enable), 0);
    chk("rst_layer", int'(ifc.eng_layer), 0);
    chk("rst_in_size", int'(ifc.eng_in_size), SIZE0);
    chk("rst_out_size", int'(ifc.eng_out_size), SIZE1);
    chk("rst_in_valid", int'(ifc.eng_input_valid), 0);
    chk("rst_in_data", int'(ifc.eng_input_data), 0);
  endtask

  task automatic load_a();
    for (int i = 0; i < SIZE0; i++) begin
      @(posedge clk); #1;
      act_wr_en   = 1'b1;
      act_wr_addr = AW'(i);
      act_wr_data = mA[i];
    end
    @(posedge clk); #1;
    act_wr_en = 1'b0;
  endtask

  initial begin
    res_t x;
    int prev, c, cnt;
    bit done_seen;
    reset_n = 1'b0; start = 1'b0; act_wr_en = 1'b0;
    act_wr_addr = '0; act_wr_data = '0; kill = 1'b0;
    start_to = 1'b0;
    ifc_to.eng_input_addr = '0; ifc_to.eng_output_data = '0;
    ifc_to.eng_output_addr = '0; ifc_to.eng_output_valid = 1'b0; ifc_to.eng_done = 1'b0;
    neg_l0 = -1; neg_l2 = -1; bad_l1 = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int t = 0; t < 5; t++) begin
      neg_l0 = -1; neg_l2 = -1; bad_l1 = 1'b0;
      for (int i = 0; i < SIZE0; i++)
        mA[i] = (t == 0) ? DW'(i + 1) : DW'($urandom_range(0, 65535));
      if (t == 1 || t == 4) begin
        neg_l0 = $urandom_range(0, SIZE1 - 1);
        neg_l2 = $urandom_range(0, SIZE3 - 1);
      end
      if (t == 2) bad_l1 = 1'b1;
      load_a();
      build_model();

      launch_q.push_back(cfg_code(0, SIZE0, SIZE1));
      launch_q.push_back(cfg_code(1, SIZE1, SIZE2));
      launch_q.push_back(cfg_code(2, SIZE2, SIZE3));
      for (int j = 0; j < SIZE3; j++) x.r[j*DW +: DW] = mL2[j];
      x.e    = bad_l1;
      x.code = bad_l1 ? 2'd2 : 2'd0;
      res_q.push_back(x);
      prev = results_seen;

      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      chk("start_busy", int'(busy), 1);
      chk("start_err_clr", int'(err), 0);

      if (t == 0) begin
        // Start and a buffer-A write while busy must both be dropped.
        repeat (3) @(posedge clk); #1;
        start = 1'b1; act_wr_en = 1'b1;
        act_wr_addr = AW'(300); act_wr_data = 16'h7777;
        @(posedge clk); #1;
        start = 1'b0; act_wr_en = 1'b0;
      end

      if (t == 3) begin
        for (c = 0; c < 5000; c++) begin
          @(negedge clk);
          if (ifc.eng_layer == 2'd1 && busy) break;
        end
        chk("reach_layer1", int'(ifc.eng_layer), 1);
        repeat (20) @(negedge clk);
        @(posedge clk); #2;
        kill = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        launch_q.delete();
        res_q.delete();
        @(negedge clk);
        check_reset_state();
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        kill = 1'b0;
        $display("inference %0d: aborted by reset during layer 1", t);
      end else begin
        for (c = 0; c < 6000; c++) begin
          @(negedge clk);
          if (results_seen != prev) break;
        end
        chk("done_seen", results_seen - prev, 1);
        repeat (SIZE3 + 3) @(negedge clk);
        $display("inference %0d: done err=%0d code=%0d neg_l0=%0d neg_l2=%0d bad_l1=%0d",
                 t, err, err_code, neg_l0, neg_l2, bad_l1);
      end
    end

    // Timeout instance: engine never reports done.
    @(posedge clk); #1; start_to = 1'b1;
    @(posedge clk); #1; start_to = 1'b0;
    for (c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ifc_to.eng_enable) break;
    end
    chk("to_launch", int'(ifc_to.eng_enable), 1);
    cnt = 0; done_seen = 1'b0;
    for (c = 0; c < 300; c++) begin
      @(negedge clk);
      cnt++;
      if (done_to) done_seen = 1'b1;
      if (!busy_to) break;
    end
    chk("to_busy_fall", cnt, 101);
    chk("to_err", int'(err_to), 1);
    chk("to_code", int'(err_code_to), 1);
    @(negedge clk);
    if (done_to) done_seen = 1'b1;
    chk("to_no_done", int'(done_seen), 0);
    $display("timeout run: busy fell after %0d cycles err=%0d code=%0d", cnt, err_to, err_code_to);

    chk("queues_empty", launch_q.size() + res_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
